regfile_wb_sched: RTL

- Write-port scheduler and scoreboard for the single-write-port, write-through register file.
- Shares the one write port between two requesters: the in-order pipeline writeback, and a long-latency unit (divider/load miss) that returns results out of band.
- Tracks registers with pending long-latency results and stalls issue on RAW and WAW hazards against them.
- Sits between decode/issue, the WB stage, the long-latency unit and the register file write port.

---
 rtl/rv_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/regfile_wb_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared register-file types and sizes for the writeback scheduler slice.
package rv_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREG   = 32;

   typedef logic [REG_AW-1:0] regaddr_t;
   typedef logic [XLEN-1:0]   xword_t;

   localparam regaddr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on long issue,
// cleared on long-unit writeback; set wins when both hit the same register.
module reg_scoreboard
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  regaddr_t        set_addr,
   input  logic            clr_en,
   input  regaddr_t        clr_addr,
   input  regaddr_t        rs1,
   input  regaddr_t        rs2,
   input  regaddr_t        rd,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            rd_busy,
   output logic [NREG-1:0] busy
);
   logic [NREG-1:0] busy_q, busy_d, set_mask, clr_mask, eff_busy;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && set_addr != REG_ZERO) set_mask = NREG'(1) << set_addr;
      if (clr_en && clr_addr != REG_ZERO) clr_mask = NREG'(1) << clr_addr;
      // Readers see a same-cycle clear through the register file bypass.
      eff_busy = busy_q & ~clr_mask;
      busy_d   = eff_busy | set_mask;
      rs1_busy = (rs1 != REG_ZERO) && eff_busy[rs1];
      rs2_busy = (rs2 != REG_ZERO) && eff_busy[rs2];
      rd_busy  = (rd  != REG_ZERO) && eff_busy[rd];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;
endmodule

// File: rtl/regfile_wb_sched.sv
// Shares the single register-file write port between pipeline WB and the
// long-latency unit, and stalls issue on hazards against pending long results.
module regfile_wb_sched
   import rv_pkg::*;
#(
   parameter int MAX_OUT    = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   input  logic [REG_AW-1:0]   issue_rs1,
   input  logic [REG_AW-1:0]   issue_rs2,
   input  logic [REG_AW-1:0]   issue_rd,
   input  logic                issue_long,
   output logic                issue_stall,
   input  logic                wb_valid,
   input  logic [REG_AW-1:0]   wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                lu_valid,
   input  logic [REG_AW-1:0]   lu_rd,
   input  logic [XLEN-1:0]     lu_data,
   output logic                lu_ready,
   output logic                rf_we,
   output logic [REG_AW-1:0]   rf_rd,
   output logic [XLEN-1:0]     rf_wd,
   output logic [3:0]          outstanding,
   output logic                err
);
   localparam int SW = $clog2(STARVE_MAX) + 1;

   logic [3:0]      out_cnt_q, out_cnt_d;
   logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
   logic            force_stall_q, force_stall_d;
   logic            err_q, err_d;
   logic            pw, lu_grant, denied, iss, inc, dec;
   logic            rs1_busy, rs2_busy, rd_busy;
   logic [NREG-1:0] busy;

   reg_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (iss && issue_long),
      .set_addr (issue_rd),
      .clr_en   (lu_grant),
      .clr_addr (lu_rd),
      .rs1      (issue_rs1),
      .rs2      (issue_rs2),
      .rd       (issue_rd),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy),
      .busy     (busy)
   );

   always_comb begin
      // The pipeline cannot be backpressured, so it always owns the port.
      pw       = wb_valid && (wb_rd != REG_ZERO);
      lu_ready = rst_n && !pw;
      lu_grant = lu_valid && lu_ready;
      denied   = lu_valid && !lu_ready;
      rf_we    = 1'b0;
      rf_rd    = REG_ZERO;
      rf_wd    = '0;
      if (pw) begin
         rf_we = 1'b1;
         rf_rd = wb_rd;
         rf_wd = wb_data;
      end else if (lu_valid) begin
         rf_we = (lu_rd != REG_ZERO);
         rf_rd = lu_rd;
         rf_wd = lu_data;
      end
      if (!rst_n) rf_we = 1'b0;

      issue_stall = !rst_n || force_stall_q ||
                    (issue_valid && (rs1_busy || rs2_busy || rd_busy ||
                     (issue_long && out_cnt_q == 4'(MAX_OUT) && !lu_grant)));
      iss = issue_valid && !issue_stall;
      inc = iss && issue_long;
      dec = lu_grant;

      out_cnt_d = out_cnt_q + {3'b0, inc} - {3'b0, dec};
      // A stray result with nothing in flight is flagged as err, not wrapped.
      if (dec && !inc && out_cnt_q == 4'd0) out_cnt_d = 4'd0;

      starve_cnt_d = '0;
      if (denied && starve_cnt_q != SW'(STARVE_MAX - 1))
         starve_cnt_d = starve_cnt_q + SW'(1);
      else if (denied)
         starve_cnt_d = starve_cnt_q;

      force_stall_d = force_stall_q;
      if (lu_grant)
         force_stall_d = 1'b0;
      else if (denied && starve_cnt_q == SW'(STARVE_MAX - 1))
         force_stall_d = 1'b1;

      err_d = err_q;
      if (lu_grant && ((out_cnt_q == 4'd0 && !inc) ||
                       (lu_rd != REG_ZERO && !busy[lu_rd])))
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_cnt_q     <= '0;
         starve_cnt_q  <= '0;
         force_stall_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         out_cnt_q     <= out_cnt_d;
         starve_cnt_q  <= starve_cnt_d;
         force_stall_q <= force_stall_d;
         err_q         <= err_d;
      end
   end

   assign outstanding = out_cnt_q;
   assign err         = err_q;
endmodule
